// File: rtl/fifo_host_sequencer_if.sv
// Handshake and command bundle between fifo_host_sequencer and its surroundings:
// upstream write stream, downstream read stream, flush and the FIFO command/status port.
interface fifo_host_sequencer_if #(
  parameter int width = 7
);
  logic             wr_valid;
  logic [width:0]   wr_data;
  logic             wr_ready;

  logic             rd_valid;
  logic [width:0]   rd_data;
  logic             rd_ready;

  logic             flush;

  logic             fifo_start;
  logic             fifo_write;
  logic [width:0]   fifo_data_in;
  logic             fifo_clear;
  logic [width:0]   fifo_data_out;
  logic             fifo_done;
  logic             fifo_empty;
  logic             fifo_full;

  logic             timeout_err;

  // The sequencer is the initiator of FIFO transactions.
  modport master (
    input  wr_valid, wr_data, rd_ready, flush,
           fifo_data_out, fifo_done, fifo_empty, fifo_full,
    output wr_ready, rd_valid, rd_data,
           fifo_start, fifo_write, fifo_data_in, fifo_clear, timeout_err
  );

  modport slave (
    output wr_valid, wr_data, rd_ready, flush,
           fifo_data_out, fifo_done, fifo_empty, fifo_full,
    input  wr_ready, rd_valid, rd_data,
           fifo_start, fifo_write, fifo_data_in, fifo_clear, timeout_err
  );
endinterface

// File: rtl/fifo_host_sequencer.sv
// Initiator-side sequencer turning write/read valid/ready streams into single FIFO
// start/write/done transactions. Optional hung-transaction watchdog: FIFO_HOST_TIMEOUT_EN.
module fifo_host_sequencer #(
  parameter int width   = 7,
  parameter int TIMEOUT = 15
) (
  input logic                    clk,
  input logic                    rst_n,
  fifo_host_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_WAIT,
    RD_REQ,
    RD_WAIT,
    CLEAR
  } state_t;

  state_t state;
  logic   prio;        // 0: write first, 1: read first
  logic   clr_second;  // second cycle of CLEAR
  logic   rd_elig;
  logic   wr_grant;
  logic   wait_abort;

  if (TIMEOUT < 1 || TIMEOUT > 15) begin : g_bad_timeout
    $error("TIMEOUT must fit the 4-bit wait counter (1..15)");
  end

  assign rd_elig     = !bus.fifo_empty && !bus.rd_valid;
  assign wr_grant    = (state == IDLE) && !bus.flush && !bus.fifo_full && !(rd_elig && prio);
  assign bus.wr_ready = wr_grant;

`ifdef FIFO_HOST_TIMEOUT_EN
  localparam logic [3:0] TIMEOUT_LAST = 4'(TIMEOUT - 1);

  logic [3:0] wait_cnt;
  logic       timeout_err;

  // Abort when this done-less WAIT cycle is the one that brings the count to TIMEOUT.
  assign wait_abort = ((state == WR_WAIT) || (state == RD_WAIT)) &&
                      !bus.fifo_done && (wait_cnt == TIMEOUT_LAST);
  assign bus.timeout_err = timeout_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt    <= 4'd0;
      timeout_err <= 1'b0;
    end else begin
      if ((state == WR_REQ) || (state == RD_REQ)) begin
        wait_cnt <= 4'd0;
      end else if (((state == WR_WAIT) || (state == RD_WAIT)) && !bus.fifo_done) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
      if (wait_abort) begin
        timeout_err <= 1'b1;
      end
    end
  end
`else
  assign wait_abort      = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      prio             <= 1'b0;
      clr_second       <= 1'b0;
      bus.fifo_start   <= 1'b0;
      bus.fifo_write   <= 1'b0;
      bus.fifo_data_in <= '0;
      bus.fifo_clear   <= 1'b0;
      bus.rd_valid     <= 1'b0;
      bus.rd_data      <= '0;
    end else begin
      // NOTE: non-blocking default followed by overrides; the last assignment in the
      // block wins, so fifo_start is a single-cycle pulse unless re-armed below.
      bus.fifo_start <= 1'b0;
      if (bus.rd_valid && bus.rd_ready) begin
        bus.rd_valid <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (bus.flush) begin
            state          <= CLEAR;
            bus.fifo_clear <= 1'b1;
            bus.rd_valid   <= 1'b0;
            clr_second     <= 1'b0;
          end else if (bus.wr_valid && wr_grant) begin
            state            <= WR_REQ;
            bus.fifo_data_in <= bus.wr_data;
            bus.fifo_start   <= 1'b1;
            bus.fifo_write   <= 1'b1;
            prio             <= 1'b1;
          end else if (rd_elig && (prio || !bus.wr_valid || bus.fifo_full)) begin
            state          <= RD_REQ;
            bus.fifo_start <= 1'b1;
            bus.fifo_write <= 1'b0;
            prio           <= 1'b0;
          end
        end

        WR_REQ: state <= WR_WAIT;

        WR_WAIT: begin
          if (bus.fifo_done || wait_abort) begin
            state          <= IDLE;
            bus.fifo_write <= 1'b0;
          end
        end

        RD_REQ: state <= RD_WAIT;

        RD_WAIT: begin
          if (bus.fifo_done) begin
            state        <= IDLE;
            bus.rd_data  <= bus.fifo_data_out;
            bus.rd_valid <= 1'b1;
          end else if (wait_abort) begin
            state <= IDLE;
          end
        end

        CLEAR: begin
          if (clr_second) begin
            state          <= IDLE;
            bus.fifo_clear <= 1'b0;
            prio           <= 1'b0;
            clr_second     <= 1'b0;
          end else begin
            clr_second <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_host_sequencer.sv
// Directed self-checking bench for fifo_host_sequencer; inputs change and outputs are
// sampled on the falling edge. Timeout checks follow FIFO_HOST_TIMEOUT_EN.
module tb_fifo_host_sequencer;

  logic clk;
  logic rst_n;

  fifo_host_sequencer_if #(.width(7)) sif ();

  fifo_host_sequencer #(.width(7), .TIMEOUT(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cd       = 0;
  bit log_q[$];   // 1 = write, 0 = read, one entry per observed fifo_start

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // FIFO model: logs each start and answers fifo_done two cycles after it.
  task automatic cycle_resp();
    @(negedge clk);
    sif.fifo_done = 1'b0;
    if (sif.fifo_start) begin
      log_q.push_back(sif.fifo_write);
      cd = 2;
    end else if (cd > 0) begin
      cd--;
      if (cd == 0) sif.fifo_done = 1'b1;
    end
  endtask

  initial begin
    int writes;
    int alt_ok;
    int got_rd;

    rst_n             = 1'b0;
    sif.wr_valid      = 1'b0;
    sif.wr_data       = 8'h00;
    sif.rd_ready      = 1'b0;
    sif.flush         = 1'b0;
    sif.fifo_data_out = 8'h00;
    sif.fifo_done     = 1'b0;
    sif.fifo_empty    = 1'b1;
    sif.fifo_full     = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_fifo_start", sif.fifo_start, 1'b0);
    check("rst_fifo_write", sif.fifo_write, 1'b0);
    check("rst_fifo_data_in", sif.fifo_data_in, 8'h00);
    check("rst_fifo_clear", sif.fifo_clear, 1'b0);
    check("rst_rd_valid", sif.rd_valid, 1'b0);
    check("rst_rd_data", sif.rd_data, 8'h00);
    check("rst_timeout_err", sif.timeout_err, 1'b0);
    rst_n = 1'b1;

    // Single write of 0xA5, done two cycles after start
    @(negedge clk);
    sif.wr_valid = 1'b1;
    sif.wr_data  = 8'hA5;
    #1 check("wr_ready_idle", sif.wr_ready, 1'b1);
    @(negedge clk);
    sif.wr_valid = 1'b0;
    sif.wr_data  = 8'h00;
    check("wr_start", sif.fifo_start, 1'b1);
    check("wr_write_req", sif.fifo_write, 1'b1);
    check("wr_data_req", sif.fifo_data_in, 8'hA5);
    check("wr_ready_req", sif.wr_ready, 1'b0);
    @(negedge clk);
    check("wr_start_pulse", sif.fifo_start, 1'b0);
    check("wr_write_wait", sif.fifo_write, 1'b1);
    check("wr_ready_wait", sif.wr_ready, 1'b0);
    @(negedge clk);
    sif.fifo_done = 1'b1;
    check("wr_write_done", sif.fifo_write, 1'b1);
    check("wr_data_done", sif.fifo_data_in, 8'hA5);
    check("wr_start_done", sif.fifo_start, 1'b0);

    // Read returning 0x3C; prio is now read-first
    @(negedge clk);
    sif.fifo_done  = 1'b0;
    sif.fifo_empty = 1'b0;
    check("wr_write_idle", sif.fifo_write, 1'b0);
    #1 check("wr_ready_rd_prio", sif.wr_ready, 1'b0);
    @(negedge clk);
    check("rd_start", sif.fifo_start, 1'b1);
    check("rd_write", sif.fifo_write, 1'b0);
    @(negedge clk);
    sif.fifo_done     = 1'b1;
    sif.fifo_data_out = 8'h3C;
    check("rd_valid_wait", sif.rd_valid, 1'b0);
    @(negedge clk);
    sif.fifo_done     = 1'b0;
    sif.fifo_data_out = 8'h00;
    check("rd_valid_set", sif.rd_valid, 1'b1);
    check("rd_data_3c", sif.rd_data, 8'h3C);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rd_hold_no_start", sif.fifo_start, 1'b0);
      check("rd_hold_valid", sif.rd_valid, 1'b1);
    end
    sif.fifo_empty = 1'b1;
    sif.rd_ready   = 1'b1;
    @(negedge clk);
    check("rd_consumed", sif.rd_valid, 1'b0);

    // Reset, then alternate write/read with both sources always ready
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    log_q.delete();
    cd = 0;
    sif.wr_valid      = 1'b1;
    sif.wr_data       = 8'h11;
    sif.fifo_empty    = 1'b0;
    sif.fifo_data_out = 8'h77;
    repeat (40) cycle_resp();
    sif.wr_valid   = 1'b0;
    sif.fifo_empty = 1'b1;
    repeat (10) cycle_resp();
    check("alt_enough_txns", (log_q.size() >= 6) ? 1 : 0, 1);
    alt_ok = 1;
    for (int i = 0; i < log_q.size(); i++) begin
      if (log_q[i] != ((i % 2) == 0)) alt_ok = 0;
    end
    check("alt_pattern_w_r", alt_ok, 1);

    // FIFO full: writes blocked, reads still served
    log_q.delete();
    sif.fifo_full = 1'b1;
    sif.wr_valid  = 1'b1;
    sif.wr_data   = 8'h22;
    #1 check("full_wr_ready", sif.wr_ready, 1'b0);
    repeat (5) cycle_resp();
    check("full_no_write", log_q.size(), 0);
    sif.fifo_empty = 1'b0;
    repeat (12) cycle_resp();
    sif.fifo_empty = 1'b1;
    repeat (8) cycle_resp();
    writes = 0;
    foreach (log_q[i]) if (log_q[i]) writes++;
    check("full_reads_issued", (log_q.size() >= 2) ? 1 : 0, 1);
    check("full_writes", writes, 0);
    sif.fifo_full = 1'b0;
    sif.wr_valid  = 1'b0;
    repeat (3) cycle_resp();

    // Hold one read word, then flush during WR_WAIT
    sif.rd_ready   = 1'b0;
    sif.fifo_empty = 1'b0;
    sif.fifo_data_out = 8'h5C;
    got_rd = 0;
    for (int i = 0; i < 12; i++) begin
      cycle_resp();
      if (sif.rd_valid) begin
        got_rd = 1;
        break;
      end
    end
    sif.fifo_empty = 1'b1;
    check("flush_pre_rd_valid", got_rd, 1);
    check("flush_pre_rd_data", sif.rd_data, 8'h5C);
    sif.wr_valid = 1'b1;
    sif.wr_data  = 8'h5A;
    @(negedge clk);
    sif.wr_valid = 1'b0;
    check("flush_wr_start", sif.fifo_start, 1'b1);
    check("flush_wr_data", sif.fifo_data_in, 8'h5A);
    @(negedge clk);
    sif.flush = 1'b1;
    check("flush_defer_wait1", sif.fifo_clear, 1'b0);
    @(negedge clk);
    check("flush_defer_wait2", sif.fifo_clear, 1'b0);
    check("flush_write_held", sif.fifo_write, 1'b1);
    sif.fifo_done = 1'b1;
    @(negedge clk);
    sif.fifo_done = 1'b0;
    check("flush_idle_clear", sif.fifo_clear, 1'b0);
    check("flush_idle_rd_valid", sif.rd_valid, 1'b1);
    #1 check("flush_wr_ready", sif.wr_ready, 1'b0);
    @(negedge clk);
    sif.flush = 1'b0;
    check("flush_clear_c1", sif.fifo_clear, 1'b1);
    check("flush_rd_valid_cleared", sif.rd_valid, 1'b0);
    @(negedge clk);
    check("flush_clear_c2", sif.fifo_clear, 1'b1);
    check("flush_no_start", sif.fifo_start, 1'b0);
    @(negedge clk);
    check("flush_clear_done", sif.fifo_clear, 1'b0);
    @(negedge clk);
    check("flush_clear_stays_low", sif.fifo_clear, 1'b0);

    // Read with no fifo_done
    sif.fifo_empty = 1'b0;
    sif.fifo_data_out = 8'h99;
    @(negedge clk);
    sif.fifo_empty = 1'b1;
    check("to_rd_start", sif.fifo_start, 1'b1);
    check("to_rd_write", sif.fifo_write, 1'b0);
    repeat (15) @(negedge clk);
    check("to_err_before", sif.timeout_err, 1'b0);
    check("to_no_start", sif.fifo_start, 1'b0);
    @(negedge clk);
`ifdef FIFO_HOST_TIMEOUT_EN
    check("to_err_set", sif.timeout_err, 1'b1);
    check("to_rd_valid", sif.rd_valid, 1'b0);
    #1 check("to_back_idle", sif.wr_ready, 1'b1);
    repeat (5) @(negedge clk);
    check("to_err_sticky", sif.timeout_err, 1'b1);
    check("to_rd_valid_late", sif.rd_valid, 1'b0);
`else
    check("nto_err_low", sif.timeout_err, 1'b0);
    #1 check("nto_still_wait", sif.wr_ready, 1'b0);
    sif.fifo_done = 1'b1;
    @(negedge clk);
    sif.fifo_done = 1'b0;
    check("nto_rd_valid", sif.rd_valid, 1'b1);
    check("nto_rd_data", sif.rd_data, 8'h99);
    sif.rd_ready = 1'b1;
    @(negedge clk);
    sif.rd_ready = 1'b0;
    check("nto_consumed", sif.rd_valid, 1'b0);
`endif

    // Reset in the middle of a write transaction
    sif.wr_valid = 1'b1;
    sif.wr_data  = 8'hC3;
    @(negedge clk);
    sif.wr_valid = 1'b0;
    check("mid_wr_start", sif.fifo_start, 1'b1);
    check("mid_wr_data", sif.fifo_data_in, 8'hC3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_write", sif.fifo_write, 1'b0);
    check("mid_rst_data_in", sif.fifo_data_in, 8'h00);
    check("mid_rst_rd_data", sif.rd_data, 8'h00);
    check("mid_rst_err", sif.timeout_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("mid_rst_idle", sif.wr_ready, 1'b1);
    @(negedge clk);
    check("mid_rst_no_start", sif.fifo_start, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_host_sequencer.md
# fifo_host_sequencer

Initiator-side sequencer that drives the FIFO block's start/write/done command interface. It turns an upstream valid/ready write stream and a downstream valid/ready read stream into single FIFO transactions, alternating priority between them. It also issues clear requests and optionally detects a hung transaction. It sits between the user datapath and the FIFO `top`, in place of hand-driven start/write/ClearAllReg.

## Interface
Parameters:
- `width`, 7: data MSB index; the data bus is width+1 bits.
- `TIMEOUT`, 15: maximum WAIT-state cycles allowed for `fifo_done`, 4-bit counter.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wr_valid`  in  1  upstream word available.
- `wr_data`  in  width+1  upstream word.
- `wr_ready`  out  1  upstream word accepted when `wr_valid & wr_ready`.
- `rd_valid`  out  1  downstream word held.
- `rd_data`  out  width+1  downstream word.
- `rd_ready`  in  1  downstream consumes the word when `rd_valid & rd_ready`.
- `flush`  in  1  request to clear the FIFO and the output holding register.
- `fifo_start`  out  1  one-cycle transaction pulse to the FIFO.
- `fifo_write`  out  1  1 = write, 0 = read; held through the transaction.
- `fifo_data_in`  out  width+1  write data; held through the transaction.
- `fifo_clear`  out  1  drives the FIFO ClearAllReg.
- `fifo_data_out`  in  width+1  FIFO read data.
- `fifo_done`  in  1  FIFO transaction complete.
- `fifo_empty`, `fifo_full`  in  1  FIFO status.
- `timeout_err`  out  1  sticky hung-transaction flag.

## Operation
- States: IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, CLEAR.
- `prio` bit: 0 = write first, 1 = read first.
- `rd_elig = !fifo_empty & !rd_valid`.
- `wr_grant = IDLE & !flush & !fifo_full & !(rd_elig & prio)`.
- `wr_ready = wr_grant`. This is combinational and does not depend on `wr_valid`.
- IDLE transitions, in priority order:
  - `flush` → CLEAR.
  - `wr_valid & wr_grant` → latch `wr_data` into `fifo_data_in`, go to WR_REQ, set `prio = 1`.
  - `rd_elig & (prio | !wr_valid | fifo_full)` → go to RD_REQ, set `prio = 0`.
  - Otherwise stay in IDLE.
- Status inputs `fifo_empty` and `fifo_full` are sampled only in IDLE.
- `fifo_done` is ignored outside the WAIT states.
- WR_REQ: `fifo_start = 1`, `fifo_write = 1`, then go to WR_WAIT.
- WR_WAIT: `fifo_write = 1`; on `fifo_done`, go to IDLE.
- RD_REQ: `fifo_start = 1`, `fifo_write = 0`, then go to RD_WAIT.
- RD_WAIT: on `fifo_done`, capture `fifo_data_out` into `rd_data`, set `rd_valid`, go to IDLE.
- `rd_valid` clears on `rd_valid & rd_ready`. Only one word is ever held, so a read is never issued while `rd_valid = 1`.
- CLEAR:
  - `fifo_clear = 1` for exactly 2 cycles.
  - `rd_valid` clears on entry.
  - Returns to IDLE and sets `prio = 0`.
- `flush` asserted outside IDLE is deferred. It is honoured on the first IDLE cycle in which it is still high; it is not latched.
- Reset (`rst_n = 0`, any state, including mid-transaction):
  - state = IDLE.
  - All outputs 0, with `rd_data` and `fifo_data_in` = 0.
  - `prio = 0`, timeout counter = 0, `timeout_err = 0`.
  - An in-flight FIFO transaction is abandoned; no recovery is attempted.

## Timing
- Write accepted in cycle N: `fifo_start` is high in N+1 only. WR_WAIT begins at N+2, the earliest cycle `fifo_done` is honoured. Done in cycle M gives IDLE at M+1.
- Read granted in IDLE cycle N: `fifo_start` is high in N+1. Done in cycle M gives `rd_valid = 1` and `rd_data` valid at M+1, with state IDLE at M+1.
- `fifo_write` and `fifo_data_in` are stable from the start cycle through the done cycle.
- Consecutive transactions are separated by at least one IDLE cycle.
- `timeout_err` rises the cycle after the timeout count is reached and stays high until reset.

## Configuration
- Macro: `FIFO_HOST_TIMEOUT_EN`.
- Defined:
  - A 4-bit counter clears on entry to WR_WAIT or RD_WAIT and increments each WAIT cycle without `fifo_done`.
  - When the counter equals `TIMEOUT`, `timeout_err` sets and the state goes to IDLE.
  - An aborted read does not set `rd_valid`.
  - `fifo_done` arriving in the same cycle the count is reached wins: the transaction completes normally.
- Undefined:
  - No counter; the WAIT states last until `fifo_done`.
  - `timeout_err` is tied to 0.

## Test plan
- Reset, then write 0xA5 with a done 2 cycles after start → `fifo_start` high for 1 cycle, `fifo_write = 1`, `fifo_data_in = 0xA5` held until done, `wr_ready` low during the transaction.
- `fifo_empty = 0`, no write pending, read done returns 0x3C → `rd_valid = 1`, `rd_data = 0x3C` the cycle after done. With `rd_ready` held low, no further `fifo_start` occurs.
- `wr_valid` held high and `fifo_empty = 0` continuously, `rd_ready = 1` → transactions alternate write, read, write, read, starting with write after reset.
- `fifo_full = 1` with `wr_valid = 1` → `wr_ready = 0` and no write is issued. Reads still proceed when `fifo_empty = 0`.
- `flush` asserted during WR_WAIT → the transaction completes, then `fifo_clear` is high for exactly 2 cycles and `rd_valid = 0`.
- With `FIFO_HOST_TIMEOUT_EN` defined and no `fifo_done` after a read start → after 15 WAIT cycles `timeout_err = 1`, state is IDLE, `rd_valid = 0`. `timeout_err` stays high until `rst_n` is pulsed.
